control_unit: RTL and testbench

- Hardwired sequencer that drives every control input of DataPath: register-select strobes, enables, ALU opcode, and memory read/write.
- Sits directly upstream of DataPath. Replaces the hand-timed T0–T7 stimulus used in the instruction benches.
- Consumes IR and the CON FF output from DataPath.
- Advances one T-step per Clock edge. Decodes IR[31:27] from step T3 onward.

---
 rtl/control_unit.sv | 122 ++++++++++++
 tb/tb_control_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: hardwired T-step sequencer driving every DataPath control input.
// Moore decode of state and IR; CON_FF gates only the branch-taken step.
module control_unit #(
  parameter int OP_W = 5,
  parameter logic [OP_W-1:0] ADD_CODE = 5'b00011
) (
  input  logic            Clock,
  input  logic            clr,
  input  logic [31:0]     IR,
  input  logic            CON_FF,
  input  logic            Stop,
  output logic            Run,
  output logic            PC_out,
  output logic            ZHigh_out,
  output logic            ZLow_out,
  output logic            HI_out,
  output logic            LO_out,
  output logic            C_out,
  output logic            MDR_out,
  output logic            in_port_out,
  output logic            BA_out,
  output logic            MAR_enable,
  output logic            Z_enable,
  output logic            Y_enable,
  output logic            PC_enable,
  output logic            IR_enable,
  output logic            MDR_enable,
  output logic            LO_enable,
  output logic            HI_enable,
  output logic            out_port_enable,
  output logic            RAM_write_enable,
  output logic            con_in,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            R_in,
  output logic            R_out,
  output logic            IncPC,
  output logic            Read,
  output logic [OP_W-1:0] opcode
);
  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, RST, HALT} state_t;
  state_t state, next;
  logic [OP_W-1:0] op;
  logic unused_ir;
  logic rtype, imm, alu2, negnot, muldiv, ldi, ld, st, mem, br, single, is_halt;
  logic [2:0] last;
  assign op = IR[31 -: OP_W];
  assign unused_ir = ^IR[31-OP_W:0];
  assign rtype = op >= 5'd3 && op <= 5'd11;
  assign imm = op >= 5'd12 && op <= 5'd14;
  assign alu2 = rtype | imm;
  assign negnot = op == 5'd17 || op == 5'd18;
  assign muldiv = op == 5'd16 || op == 5'd15;
  assign ldi = op == 5'd1;
  assign ld = op == 5'd0;
  assign st = op == 5'd2;
  assign mem = ld | st | ldi;
  assign br = op == 5'd19;
  assign single = op == 5'd20 || op == 5'd22 || op == 5'd23 || op == 5'd24 || op == 5'd25;
  assign is_halt = op == 5'd27;
  // Final T-step of each instruction class; nop, halt and undefined end at T2.
  assign last = (ld | st) ? 3'd7 : (muldiv | br) ? 3'd6 : (alu2 | ldi) ? 3'd5 :
                negnot ? 3'd4 : single ? 3'd3 : 3'd2;
  assign next = state == RST ? T0 : state == HALT ? HALT :
                state[2:0] == last ? ((Stop || is_halt) ? HALT : T0) : state_t'(state + 4'd1);
  always_ff @(posedge Clock or negedge clr)
    if (!clr) state <= RST;
    else state <= next;
  always_comb begin
    {PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out, BA_out} = '0;
    {MAR_enable, Z_enable, Y_enable, PC_enable, IR_enable, MDR_enable, LO_enable, HI_enable} = '0;
    {out_port_enable, RAM_write_enable, con_in, Gra, Grb, Grc, R_in, R_out, IncPC, Read} = '0;
    opcode = '0;
    Run = state != HALT;
    case (state)
      T0: {PC_out, MAR_enable, IncPC, PC_enable} = '1;
      T1: {Read, MDR_enable} = '1;
      T2: {MDR_out, IR_enable} = '1;
      T3: begin
        if (alu2 || muldiv) begin Gra = muldiv; Grb = !muldiv; R_out = 1'b1; Y_enable = 1'b1; end
        if (negnot) begin Grb = 1'b1; R_out = 1'b1; opcode = op; Z_enable = 1'b1; end
        if (mem) begin Grb = 1'b1; BA_out = 1'b1; Y_enable = 1'b1; end
        if (br) begin Gra = 1'b1; R_out = 1'b1; con_in = 1'b1; end
        if (single) begin
          Gra = 1'b1;
          R_out = op == 5'd20 || op == 5'd23;
          R_in = op == 5'd22 || op == 5'd24 || op == 5'd25;
          PC_enable = op == 5'd20;
          in_port_out = op == 5'd22;
          out_port_enable = op == 5'd23;
          HI_out = op == 5'd24;
          LO_out = op == 5'd25;
        end
      end
      T4: begin
        if (alu2) begin Grc = rtype; R_out = rtype; C_out = imm; opcode = op; Z_enable = 1'b1; end
        if (negnot) begin ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        if (muldiv) begin Grb = 1'b1; R_out = 1'b1; opcode = op; Z_enable = 1'b1; end
        if (mem) begin C_out = 1'b1; opcode = ADD_CODE; Z_enable = 1'b1; end
        if (br) begin PC_out = 1'b1; Y_enable = 1'b1; end
      end
      T5: begin
        if (alu2 || ldi) begin ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        if (muldiv) begin ZLow_out = 1'b1; LO_enable = 1'b1; end
        if (ld || st) begin ZLow_out = 1'b1; MAR_enable = 1'b1; end
        if (br) begin C_out = 1'b1; opcode = ADD_CODE; Z_enable = 1'b1; end
      end
      T6: begin
        if (muldiv) begin ZHigh_out = 1'b1; HI_enable = 1'b1; end
        if (ld) begin Read = 1'b1; MDR_enable = 1'b1; end
        if (st) begin Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1; end
        if (br) begin ZLow_out = CON_FF; PC_enable = CON_FF; end
      end
      T7: begin
        if (ld) begin MDR_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        if (st) RAM_write_enable = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed per-step checks of control_unit strobe sequences.
module tb_control_unit;
  typedef logic [32:0] vec_t;
  localparam logic [26:0] PCO = 27'd1 << 26, ZHO = 27'd1 << 25, ZLO = 27'd1 << 24, HIO = 27'd1 << 23;
  localparam logic [26:0] LOO = 27'd1 << 22, CO = 27'd1 << 21, MDRO = 27'd1 << 20, INO = 27'd1 << 19;
  localparam logic [26:0] BAO = 27'd1 << 18, MARE = 27'd1 << 17, ZE = 27'd1 << 16, YE = 27'd1 << 15;
  localparam logic [26:0] PCE = 27'd1 << 14, IRE = 27'd1 << 13, MDRE = 27'd1 << 12, LOE = 27'd1 << 11;
  localparam logic [26:0] HIE = 27'd1 << 10, OPE = 27'd1 << 9, RAMW = 27'd1 << 8, CONI = 27'd1 << 7;
  localparam logic [26:0] GRA = 27'd1 << 6, GRB = 27'd1 << 5, GRC = 27'd1 << 4, RIN = 27'd1 << 3;
  localparam logic [26:0] ROUT = 27'd1 << 2, INC = 27'd1 << 1, RD = 27'd1;
  localparam vec_t IDLE = {1'b1, 5'd0, 27'd0};
  localparam vec_t HALTV = 33'd0;
  localparam vec_t F0 = {1'b1, 5'd0, PCO | MARE | INC | PCE};
  localparam vec_t F1 = {1'b1, 5'd0, RD | MDRE};
  localparam vec_t F2 = {1'b1, 5'd0, MDRO | IRE};
  localparam vec_t Z = 33'd0;
  logic Clock = 1'b0, clr = 1'b0, CON_FF = 1'b0, Stop = 1'b0;
  logic [31:0] IR = 32'd0;
  logic Run, PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out, BA_out;
  logic MAR_enable, Z_enable, Y_enable, PC_enable, IR_enable, MDR_enable, LO_enable, HI_enable;
  logic out_port_enable, RAM_write_enable, con_in, Gra, Grb, Grc, R_in, R_out, IncPC, Read;
  logic [4:0] opcode;
  vec_t obs;
  int checks = 0, fails = 0;
  control_unit dut (
    .Clock(Clock), .clr(clr), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
    .PC_out(PC_out), .ZHigh_out(ZHigh_out), .ZLow_out(ZLow_out), .HI_out(HI_out), .LO_out(LO_out),
    .C_out(C_out), .MDR_out(MDR_out), .in_port_out(in_port_out), .BA_out(BA_out),
    .MAR_enable(MAR_enable), .Z_enable(Z_enable), .Y_enable(Y_enable), .PC_enable(PC_enable),
    .IR_enable(IR_enable), .MDR_enable(MDR_enable), .LO_enable(LO_enable), .HI_enable(HI_enable),
    .out_port_enable(out_port_enable), .RAM_write_enable(RAM_write_enable), .con_in(con_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out), .IncPC(IncPC), .Read(Read),
    .opcode(opcode)
  );
  assign obs = {Run, opcode, PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out,
                BA_out, MAR_enable, Z_enable, Y_enable, PC_enable, IR_enable, MDR_enable, LO_enable,
                HI_enable, out_port_enable, RAM_write_enable, con_in, Gra, Grb, Grc, R_in, R_out,
                IncPC, Read};
  always #5 Clock = ~Clock;

  function automatic vec_t ex(input logic [4:0] op, input logic [26:0] m);
    return {1'b1, op, m};
  endfunction

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    clr = 1'b0;
    #1 clr = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    @(negedge Clock);
    checks++;
    if (obs !== IDLE) begin fails++; $display("FAIL reset_hold: got %h expected %h", obs, IDLE); end
    clr = 1'b1;
    tick();
    checks++;
    if (obs !== F0) begin fails++; $display("FAIL reset_release_t0: got %h expected %h", obs, F0); end
    IR = 32'h18918000;
    repeat (4) tick();
    checks++;
    if (obs !== ex(5'd3, GRC | ROUT | ZE)) begin
      fails++; $display("FAIL reset_pre_t4: got %h expected %h", obs, ex(5'd3, GRC | ROUT | ZE));
    end
    clr = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE) begin fails++; $display("FAIL reset_async_mid_t4: got %h expected %h", obs, IDLE); end
    tick();
    checks++;
    if (obs !== IDLE) begin fails++; $display("FAIL reset_held_edge: got %h expected %h", obs, IDLE); end
    clr = 1'b1;
    tick();
    checks++;
    if (obs !== F0) begin fails++; $display("FAIL reset_rerelease_t0: got %h expected %h", obs, F0); end
  endtask

  task automatic test_alu();
    string nm [5] = '{"add", "addi", "neg", "mul", "div"};
    logic [31:0] ir [5] = '{32'h18918000, 32'h60000000, 32'h88000000, 32'h80000000, 32'h78000000};
    int n [5] = '{6, 6, 5, 7, 7};
    vec_t s [5][8];
    s = '{'{F0, F1, F2, ex(0, GRB | ROUT | YE), ex(5'd3, GRC | ROUT | ZE), ex(0, ZLO | GRA | RIN), Z, Z},
          '{F0, F1, F2, ex(0, GRB | ROUT | YE), ex(5'd12, CO | ZE), ex(0, ZLO | GRA | RIN), Z, Z},
          '{F0, F1, F2, ex(5'd17, GRB | ROUT | ZE), ex(0, ZLO | GRA | RIN), Z, Z, Z},
          '{F0, F1, F2, ex(0, GRA | ROUT | YE), ex(5'd16, GRB | ROUT | ZE), ex(0, ZLO | LOE),
            ex(0, ZHO | HIE), Z},
          '{F0, F1, F2, ex(0, GRA | ROUT | YE), ex(5'd15, GRB | ROUT | ZE), ex(0, ZLO | LOE),
            ex(0, ZHO | HIE), Z}};
    for (int r = 0; r < 5; r++) begin
      IR = ir[r];
      for (int i = 0; i < n[r]; i++) begin
        checks++;
        if (obs !== s[r][i]) begin
          fails++; $display("FAIL %s T%0d: got %h expected %h", nm[r], i, obs, s[r][i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_memory();
    string nm [3] = '{"ld", "st", "ldi"};
    logic [31:0] ir [3] = '{32'h00900010, 32'h10000000, 32'h08000000};
    int n [3] = '{8, 8, 6};
    vec_t s [3][8];
    s = '{'{F0, F1, F2, ex(0, GRB | BAO | YE), ex(5'd3, CO | ZE), ex(0, ZLO | MARE), ex(0, RD | MDRE),
            ex(0, MDRO | GRA | RIN)},
          '{F0, F1, F2, ex(0, GRB | BAO | YE), ex(5'd3, CO | ZE), ex(0, ZLO | MARE),
            ex(0, GRA | ROUT | MDRE), ex(0, RAMW)},
          '{F0, F1, F2, ex(0, GRB | BAO | YE), ex(5'd3, CO | ZE), ex(0, ZLO | GRA | RIN), Z, Z}};
    for (int r = 0; r < 3; r++) begin
      IR = ir[r];
      for (int i = 0; i < n[r]; i++) begin
        checks++;
        if (obs !== s[r][i]) begin
          fails++; $display("FAIL %s T%0d: got %h expected %h", nm[r], i, obs, s[r][i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_control();
    string nm [9] = '{"br_taken", "br_not_taken", "jr", "in", "out", "mfhi", "mflo", "nop", "undef"};
    logic [31:0] ir [9] = '{32'h9A000008, 32'h9A000008, 32'hA2800000, 32'hB0000000, 32'hB8000000,
                            32'hC0000000, 32'hC8000000, 32'hD0000000, 32'hF8000000};
    logic con [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int n [9] = '{7, 7, 4, 4, 4, 4, 4, 3, 3};
    vec_t s [9][8];
    s = '{'{F0, F1, F2, ex(0, GRA | ROUT | CONI), ex(0, PCO | YE), ex(5'd3, CO | ZE), ex(0, ZLO | PCE), Z},
          '{F0, F1, F2, ex(0, GRA | ROUT | CONI), ex(0, PCO | YE), ex(5'd3, CO | ZE), IDLE, Z},
          '{F0, F1, F2, ex(0, GRA | ROUT | PCE), Z, Z, Z, Z},
          '{F0, F1, F2, ex(0, INO | GRA | RIN), Z, Z, Z, Z},
          '{F0, F1, F2, ex(0, GRA | ROUT | OPE), Z, Z, Z, Z},
          '{F0, F1, F2, ex(0, HIO | GRA | RIN), Z, Z, Z, Z},
          '{F0, F1, F2, ex(0, LOO | GRA | RIN), Z, Z, Z, Z},
          '{F0, F1, F2, Z, Z, Z, Z, Z},
          '{F0, F1, F2, Z, Z, Z, Z, Z}};
    for (int r = 0; r < 9; r++) begin
      IR = ir[r];
      CON_FF = con[r];
      for (int i = 0; i < n[r]; i++) begin
        checks++;
        if (obs !== s[r][i]) begin
          fails++; $display("FAIL %s T%0d: got %h expected %h", nm[r], i, obs, s[r][i]);
        end
        tick();
      end
    end
    checks++;
    if (obs !== F0) begin fails++; $display("FAIL back_to_back_t0: got %h expected %h", obs, F0); end
  endtask

  task automatic test_stop();
    vec_t s [6];
    s = '{F0, F1, F2, ex(0, GRB | ROUT | YE), ex(5'd3, GRC | ROUT | ZE), ex(0, ZLO | GRA | RIN)};
    IR = 32'h18918000;
    Stop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs !== s[i]) begin fails++; $display("FAIL stop_add T%0d: got %h expected %h", i, obs, s[i]); end
      tick();
    end
    Stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== HALTV) begin fails++; $display("FAIL stop_halt cyc%0d: got %h expected %h", i, obs, HALTV); end
      tick();
    end
    do_reset();
    checks++;
    if (obs !== F0) begin fails++; $display("FAIL stop_recover_t0: got %h expected %h", obs, F0); end
  endtask

  task automatic test_halt();
    vec_t s [3] = '{F0, F1, F2};
    IR = 32'hD8000000;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== s[i]) begin fails++; $display("FAIL halt_fetch T%0d: got %h expected %h", i, obs, s[i]); end
      tick();
    end
    IR = 32'h18918000;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obs !== HALTV) begin fails++; $display("FAIL halt_idle cyc%0d: got %h expected %h", i, obs, HALTV); end
      tick();
    end
    do_reset();
    checks++;
    if (obs !== F0) begin fails++; $display("FAIL halt_recover_t0: got %h expected %h", obs, F0); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_memory();
    test_control();
    test_stop();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
